// File: rtl/ppu_sprite_pkg.sv
// Shared types and helpers for the PPU sprite evaluation and fetch stages.
package ppu_sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SCAN_RD = 3'd2,
    ST_SCAN_WR = 3'd3,
    ST_DONE    = 3'd4
  } eval_state_t;

  localparam int OAM_BYTES_PER_SPRITE = 4;
  localparam int SPRITE_H_SHORT       = 8;
  localparam int SPRITE_H_TALL        = 16;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
  } oam_entry_t;

  // 9-bit unsigned distance from the sprite top to the line; a sprite above
  // the line wraps to a large value, so one compare covers both bounds.
  function automatic logic sprite_in_range(input logic [8:0] line,
                                           input logic [7:0] y,
                                           input logic       tall);
    logic [8:0] diff;
    diff = line - {1'b0, y};
    return tall ? (diff < 9'(SPRITE_H_TALL)) : (diff < 9'(SPRITE_H_SHORT));
  endfunction

endpackage

// File: rtl/secondary_oam_ram.sv
// Secondary OAM storage: one synchronous write port, one asynchronous read
// port. A read of the address being written returns the previous contents.
module secondary_oam_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Byte write, no reset: contents are meaningless until the first clear pass.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluator: clears secondary OAM, scans primary OAM two
// ticks per byte, copies up to MAX_SPRITES in-range sprites and tracks the
// sticky overflow flag (optionally with the NES diagonal-scan quirk).
//
// Handshake: evalStart is a one-tick request sampled on an enabled tick and
// is always accepted (it aborts any evaluation in progress); evalDone acts as
// the result-valid and stays high, with all results stable, until the next
// evalStart.
module sprite_line_evaluator
  import ppu_sprite_pkg::*;
#(
  parameter  int MAX_SPRITES     = 8,
  parameter  int OAM_ENTRIES     = 64,
  parameter  int HW_OVERFLOW_BUG = 1,
  localparam int SEC_DEPTH       = OAM_BYTES_PER_SPRITE * MAX_SPRITES,
  localparam int SEC_AW          = $clog2(SEC_DEPTH),
  localparam int CNT_W           = $clog2(MAX_SPRITES + 1),
  localparam int N_W             = (OAM_ENTRIES > 1) ? $clog2(OAM_ENTRIES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_EN,
  input  logic              evalStart,
  input  logic              resetFlags,
  input  logic              tallSprites,
  input  logic [8:0]        yPosition,
  output logic [7:0]        oamAddress,
  input  logic [7:0]        oamData,
  input  logic [SEC_AW-1:0] secReadIndex,
  output logic [7:0]        secReadData,
  output logic [CNT_W-1:0]  spriteCount,
  output logic              sprite0OnLine,
  output logic              spriteOverflow,
  output logic              evalDone,
  output eval_state_t       o_dbg_state
);

  eval_state_t       r_state, w_state_nxt;
  logic [N_W-1:0]    r_n, w_n_nxt;
  logic [1:0]        r_m, w_m_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [SEC_AW-1:0] r_clr_idx, w_clr_nxt;
  logic              r_sprite0, w_sprite0_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic [7:0]        r_addr_hold, w_hold_nxt;

  logic              w_in_range, w_full, w_n_last;
  logic [7:0]        w_addr_now;
  logic              w_sec_we;
  logic [SEC_AW-1:0] w_sec_waddr;
  logic [7:0]        w_sec_wdata;

  // The slot pointer is the sprite count itself: a slot is counted once its
  // fourth byte lands, so the write address is {count, byte}.
  assign w_in_range = sprite_in_range(yPosition, oamData, tallSprites);
  assign w_full     = (r_count == CNT_W'(MAX_SPRITES));
  assign w_n_last   = (r_n == N_W'(OAM_ENTRIES - 1));
  assign w_addr_now = 8'({r_n, r_m});

  // Next-state and datapath decode; evalStart overrides everything at the end.
  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_m_nxt        = r_m;
    w_count_nxt    = r_count;
    w_clr_nxt      = r_clr_idx;
    w_sprite0_nxt  = r_sprite0;
    w_overflow_nxt = resetFlags ? 1'b0 : r_overflow;
    w_hold_nxt     = r_addr_hold;
    w_sec_we       = 1'b0;
    w_sec_waddr    = SEC_AW'({r_count, r_m});
    w_sec_wdata    = oamData;
    case (r_state)
      ST_CLEAR: begin
        w_sec_we    = 1'b1;
        w_sec_waddr = r_clr_idx;
        w_sec_wdata = 8'hFF;
        if (r_clr_idx == SEC_AW'(SEC_DEPTH - 1)) w_state_nxt = ST_SCAN_RD;
        else w_clr_nxt = r_clr_idx + SEC_AW'(1);
      end
      ST_SCAN_RD: begin
        w_hold_nxt  = w_addr_now;
        w_state_nxt = ST_SCAN_WR;
      end
      ST_SCAN_WR: begin
        w_state_nxt = ST_SCAN_RD;
        if (!w_full) begin
          if (r_m == 2'd0 && !w_in_range) begin
            w_n_nxt = r_n + N_W'(1);
            if (w_n_last) w_state_nxt = ST_DONE;
          end else begin
            w_sec_we = 1'b1;
            w_m_nxt  = r_m + 2'd1;
            if (r_m == 2'd3) begin
              w_count_nxt = r_count + CNT_W'(1);
              w_n_nxt     = r_n + N_W'(1);
              if (r_count == '0 && r_n == '0) w_sprite0_nxt = 1'b1;
              if (w_n_last) w_state_nxt = ST_DONE;
            end
          end
        end else if (w_in_range) begin
          // Setting wins over a coincident resetFlags.
          w_overflow_nxt = 1'b1;
          w_state_nxt    = ST_DONE;
        end else begin
          // With the quirk the byte index drifts, so later tests read
          // tile/attr/x bytes as if they were Y coordinates.
          w_n_nxt = r_n + N_W'(1);
          w_m_nxt = (HW_OVERFLOW_BUG != 0) ? r_m + 2'd1 : 2'd0;
          if (w_n_last) w_state_nxt = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE: ;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (evalStart) begin
      w_state_nxt    = ST_CLEAR;
      w_n_nxt        = '0;
      w_m_nxt        = 2'd0;
      w_count_nxt    = '0;
      w_clr_nxt      = '0;
      w_sprite0_nxt  = 1'b0;
      w_overflow_nxt = resetFlags ? 1'b0 : r_overflow;
      w_sec_we       = 1'b0;
    end
  end

  // State register, advancing only on dot-enable ticks.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else if (clock_EN) r_state <= w_state_nxt;
  end

  // Scan pointers, counters and flags, advancing only on dot-enable ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_n         <= '0;
      r_m         <= 2'd0;
      r_count     <= '0;
      r_clr_idx   <= '0;
      r_sprite0   <= 1'b0;
      r_overflow  <= 1'b0;
      r_addr_hold <= 8'd0;
    end else if (clock_EN) begin
      r_n         <= w_n_nxt;
      r_m         <= w_m_nxt;
      r_count     <= w_count_nxt;
      r_clr_idx   <= w_clr_nxt;
      r_sprite0   <= w_sprite0_nxt;
      r_overflow  <= w_overflow_nxt;
      r_addr_hold <= w_hold_nxt;
    end
  end

  secondary_oam_ram #(.DEPTH(SEC_DEPTH), .AW(SEC_AW)) u_sec_oam (
    .i_clk   (clock),
    .i_we    (w_sec_we & clock_EN & ~reset),
    .i_waddr (w_sec_waddr),
    .i_wdata (w_sec_wdata),
    .i_raddr (secReadIndex),
    .o_rdata (secReadData)
  );

  // n has already wrapped by the time DONE is reached, so the last driven
  // address is replayed from the hold register.
  assign oamAddress     = (r_state == ST_DONE) ? r_addr_hold : w_addr_now;
  assign spriteCount    = r_count;
  assign sprite0OnLine  = r_sprite0;
  assign spriteOverflow = r_overflow;
  assign evalDone       = (r_state == ST_DONE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Bench for sprite_line_evaluator: two instances (quirk on / quirk off) share
// stimulus and a primary OAM image; each has its own expectation queue and
// monitor, fed by a line-level reference model.
module tb_sprite_line_evaluator;
  import ppu_sprite_pkg::*;

  localparam int MAXS = 8;
  localparam int ENT  = 64;
  localparam int SEC  = 4 * MAXS;

  typedef struct packed {
    logic [SEC*8-1:0] sec;
    int               ticks;
    int               cnt;
    logic             s0;
    logic             ovf;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, clock_EN, evalStart, resetFlags, tallSprites;
  logic [8:0] yPosition;
  logic [7:0] oam_mem [ENT*4];
  int         tick_cnt = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         sticky [2];
  int         pushed [2];
  int         checked [2];

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    clock_EN = 1'b0;
    forever begin
      @(negedge clock);
      clock_EN = ($urandom_range(0, 3) != 0);
    end
  end

  // enabled ticks since the last accepted evalStart
  always @(posedge clock) begin
    if (clock_EN) tick_cnt <= evalStart ? 0 : tick_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d, expected %0d", g, name, act, exp);
    end
  endtask

  function automatic bit hit(input int line, input logic [7:0] yb, input bit tall);
    int d;
    d = (line - int'(yb)) & 511;
    return d < (tall ? 16 : 8);
  endfunction

  // Reference: walk OAM the way the line's evaluation does, one byte at a time.
  function automatic exp_t model(input bit bug, input int line, input bit tall);
    exp_t e;
    int n, m, cnt, bytes;
    bit fin;
    logic [7:0] b;
    e.sec = '1; e.s0 = 1'b0; e.ovf = 1'b0;
    n = 0; m = 0; cnt = 0; bytes = 0; fin = 1'b0;
    while (!fin) begin
      b = oam_mem[n*4 + m];
      bytes++;
      if (cnt < MAXS) begin
        if (m == 0 && !hit(line, b, tall)) n++;
        else begin
          e.sec[(cnt*4 + m)*8 +: 8] = b;
          if (m == 3) begin
            if (cnt == 0 && n == 0) e.s0 = 1'b1;
            cnt++; n++; m = 0;
          end else m++;
        end
      end else if (hit(line, b, tall)) begin
        e.ovf = 1'b1; fin = 1'b1;
      end else begin
        n++;
        if (bug) m = (m + 1) % 4;
      end
      if (n == ENT) fin = 1'b1;
    end
    e.cnt   = cnt;
    e.ticks = 4*MAXS + 2*bytes;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  oam_addr, oam_data, sec_rdata;
    logic [4:0]  sec_idx;
    logic [3:0]  cnt;
    logic        s0, ovf, done;
    eval_state_t dbg;
    exp_t        exp_q [$];

    sprite_line_evaluator #(
      .MAX_SPRITES(MAXS), .OAM_ENTRIES(ENT), .HW_OVERFLOW_BUG(g == 0 ? 1 : 0)
    ) u_dut (
      .clock(clock), .reset(reset), .clock_EN(clock_EN), .evalStart(evalStart),
      .resetFlags(resetFlags), .tallSprites(tallSprites), .yPosition(yPosition),
      .oamAddress(oam_addr), .oamData(oam_data), .secReadIndex(sec_idx),
      .secReadData(sec_rdata), .spriteCount(cnt), .sprite0OnLine(s0),
      .spriteOverflow(ovf), .evalDone(done), .o_dbg_state(dbg)
    );

    // primary OAM: registered read, one enabled tick of latency
    always @(posedge clock) begin
      if (clock_EN) oam_data <= oam_mem[oam_addr];
    end

    // monitor: on each rising evalDone pop one expectation and compare
    initial begin : monitor
      exp_t e;
      logic prev;
      prev = 1'b0;
      sec_idx = '0;
      forever begin
        @(negedge clock);
        if (done === 1'b1 && prev !== 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", g, 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("spriteCount", g, 32'(cnt), 32'(e.cnt));
            check("sprite0OnLine", g, 32'(s0), 32'(e.s0));
            check("spriteOverflow", g, 32'(ovf), 32'(e.ovf));
            check("done_tick", g, 32'(tick_cnt), 32'(e.ticks));
            for (int i = 0; i < SEC; i++) begin
              sec_idx = 5'(i);
              #1;
              check($sformatf("sec[%0d]", i), g, 32'(sec_rdata), 32'(e.sec[i*8 +: 8]));
            end
          end
          checked[g]++;
        end
        prev = done;
      end
    end
  end

  // driver tasks
  task automatic pulse(input bit is_flags);
    @(negedge clock);
    if (is_flags) resetFlags = 1'b1; else evalStart = 1'b1;
    do @(posedge clock); while (!clock_EN);
    @(negedge clock);
    if (is_flags) resetFlags = 1'b0; else evalStart = 1'b0;
  endtask

  task automatic wait_checked();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (checked[0] == pushed[0] && checked[1] == pushed[1]) break;
      @(negedge clock);
    end
    if (i == 3000) begin
      $display("FAIL eval_timeout: evalDone not seen within 3000 cycles");
      n_checks++; n_fail++;
      g_dut[0].exp_q.delete(); g_dut[1].exp_q.delete();
      checked[0] = pushed[0]; checked[1] = pushed[1];
    end
  endtask

  task automatic push_expect(input int line, input bit tall, input bit flags_held);
    exp_t e0, e1;
    e0 = model(1'b1, line, tall);
    e1 = model(1'b0, line, tall);
    sticky[0] = flags_held ? e0.ovf : (sticky[0] | e0.ovf);
    sticky[1] = flags_held ? e1.ovf : (sticky[1] | e1.ovf);
    e0.ovf = sticky[0];
    e1.ovf = sticky[1];
    g_dut[0].exp_q.push_back(e0); pushed[0]++;
    g_dut[1].exp_q.push_back(e1); pushed[1]++;
  endtask

  task automatic set_line(input int line, input bit tall);
    @(negedge clock);
    yPosition   = 9'(line);
    tallSprites = tall;
  endtask

  task automatic run(input int line, input bit tall, input bit flags_held);
    set_line(line, tall);
    push_expect(line, tall, flags_held);
    pulse(1'b0);
    wait_checked();
  endtask

  task automatic fill_ff();
    for (int i = 0; i < ENT*4; i++) oam_mem[i] = 8'hFF;
  endtask

  task automatic put_sprite(input int e, input logic [7:0] y);
    oam_mem[e*4]     = y;
    oam_mem[e*4 + 1] = 8'($urandom_range(0, 255));
    oam_mem[e*4 + 2] = 8'($urandom_range(0, 255));
    oam_mem[e*4 + 3] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_count3();
    for (int i = 0; i < 3000 && g_dut[0].cnt != 4'd3; i++) @(negedge clock);
    check("reach_three_copies", 0, 32'(g_dut[0].cnt), 32'd3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_oamAddress"}, 0, 32'(g_dut[0].oam_addr), 32'd0);
    check({tag, "_oamAddress"}, 1, 32'(g_dut[1].oam_addr), 32'd0);
    check({tag, "_count"}, 0, 32'(g_dut[0].cnt), 32'd0);
    check({tag, "_count"}, 1, 32'(g_dut[1].cnt), 32'd0);
    check({tag, "_sprite0"}, 0, 32'(g_dut[0].s0), 32'd0);
    check({tag, "_sprite0"}, 1, 32'(g_dut[1].s0), 32'd0);
    check({tag, "_overflow"}, 0, 32'(g_dut[0].ovf), 32'd0);
    check({tag, "_overflow"}, 1, 32'(g_dut[1].ovf), 32'd0);
    check({tag, "_evalDone"}, 0, 32'(g_dut[0].done), 32'd0);
    check({tag, "_evalDone"}, 1, 32'(g_dut[1].done), 32'd0);
    check({tag, "_state"}, 0, 32'(g_dut[0].dbg), 32'(ST_IDLE));
    check({tag, "_state"}, 1, 32'(g_dut[1].dbg), 32'(ST_IDLE));
  endtask

  initial begin
    int line;
    reset = 1'b1; evalStart = 1'b0; resetFlags = 1'b0;
    tallSprites = 1'b0; yPosition = '0;
    sticky[0] = 1'b0; sticky[1] = 1'b0;
    pushed[0] = 0; pushed[1] = 0; checked[0] = 0; checked[1] = 0;
    fill_ff();
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;

    // 1: nothing on the line; full-length scan
    run(50, 1'b0, 1'b0);

    // 2: entries 0 and 5 on the line
    fill_ff();
    put_sprite(0, 8'd40);
    put_sprite(5, 8'd40);
    run(45, 1'b0, 1'b0);

    // 3: tall vs short sprites at the bottom edge
    run(55, 1'b1, 1'b0);
    run(55, 1'b0, 1'b0);

    // 4: ten sprites, overflow, then pre-render clear
    fill_ff();
    for (int e = 0; e < 10; e++) put_sprite(e, 8'd10);
    run(12, 1'b0, 1'b0);
    pulse(1'b1);
    sticky[0] = 1'b0; sticky[1] = 1'b0;
    check("overflow_cleared", 0, 32'(g_dut[0].ovf), 32'd0);
    check("overflow_cleared", 1, 32'(g_dut[1].ovf), 32'd0);

    // 5: diagonal-scan false overflow, with resetFlags held so the set must win
    fill_ff();
    for (int e = 0; e < 8; e++) put_sprite(e, 8'd10);
    oam_mem[8*4] = 8'd0;
    oam_mem[9*4 + 1] = 8'd12;
    @(negedge clock);
    resetFlags = 1'b1;
    run(12, 1'b0, 1'b1);
    pulse(1'b1);
    sticky[0] = 1'b0; sticky[1] = 1'b0;

    // 6a: restart mid-scan; the new line sees an empty OAM, so every
    // previously copied slot must come back as 8'hFF
    fill_ff();
    for (int e = 0; e < 5; e++) put_sprite(e, 8'd40);
    set_line(45, 1'b0);
    pulse(1'b0);
    wait_count3();
    fill_ff();
    push_expect(45, 1'b0, 1'b0);
    pulse(1'b0);
    check("restart_count", 0, 32'(g_dut[0].cnt), 32'd0);
    check("restart_count", 1, 32'(g_dut[1].cnt), 32'd0);
    check("restart_sprite0", 0, 32'(g_dut[0].s0), 32'd0);
    check("restart_evalDone", 0, 32'(g_dut[0].done), 32'd0);
    check("restart_state", 0, 32'(g_dut[0].dbg), 32'(ST_CLEAR));
    wait_checked();

    // 6b: synchronous reset in the middle of a scan
    fill_ff();
    for (int e = 0; e < 10; e++) put_sprite(e, 8'd40);
    set_line(45, 1'b0);
    pulse(1'b0);
    wait_count3();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("midscan_reset");
    reset = 1'b0;
    sticky[0] = 1'b0; sticky[1] = 1'b0;

    // random lines and OAM images
    for (int r = 0; r < 12; r++) begin
      line = $urandom_range(0, 239);
      for (int i = 0; i < ENT*4; i++) oam_mem[i] = 8'($urandom_range(0, 255));
      for (int e = 0; e < ENT; e++) begin
        if ($urandom_range(0, 99) < 20)
          oam_mem[e*4] = 8'((line - int'($urandom_range(0, 17))) & 255);
      end
      run(line, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        pulse(1'b1);
        sticky[0] = 1'b0; sticky[1] = 1'b0;
        check("rand_flags_clear", 0, 32'(g_dut[0].ovf), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
